// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle main control unit for the MIPS core.
// Steps each instruction through FETCH, DECODE, execute, memory and
// writeback states (one state per clock) and handshakes with a shared
// instruction/data memory over mem_req/mem_ready, trapping on reserved
// opcodes and on memory accesses that wait too long.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   op[5:0]             opcode from the instruction register
//   mem_ready           memory completes the current access this cycle
//   mem_req/mem_we/iord memory request, write enable, address select
//   irwrite, pcwrite    IR load, unconditional PC load
//   branch, branch_ne   BEQ / BNE conditional PC-load qualifiers
//   regdst, memtoreg, regwrite, ext_zero   register-file / immediate controls
//   alusrca, alusrcb, aluop, pcsrc         datapath multiplexer / ALU controls
//   exc_ri, exc_bus     reserved-instruction / memory-timeout pulses
//   state[3:0]          current state encoding (debug)
module mc_ctrl #(
  parameter int TIMEOUT   = 255,
  parameter int TIMEOUT_W = 8,
  parameter bit HAS_BNE   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       branch,
  output logic       branch_ne,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       ext_zero,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] pcsrc,
  output logic       exc_ri,
  output logic       exc_bus,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_RTYPE  = 4'd7,
    S_ALUWB  = 4'd8,
    S_IMMEX  = 4'd9,
    S_IMMWB  = 4'd10,
    S_BEQ    = 4'd11,
    S_BNE    = 4'd12,
    S_JUMP   = 4'd13,
    S_TRAP   = 4'd14,
    S_BAD    = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [TIMEOUT_W-1:0] LIMIT = TIMEOUT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t               cur;
  logic [TIMEOUT_W-1:0] wait_cnt;
  logic                 trap_bus;
  logic                 zext;
  logic                 at_limit;

  assign at_limit = (TIMEOUT != 0) && (wait_cnt == LIMIT);
  assign state    = cur;

  // Memory states share one rule: ready wins, otherwise trap at the limit,
  // otherwise keep counting. The counter is zeroed on every other path,
  // which clears it on entry to FETCH/MEMRD/MEMWR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur      <= S_IDLE;
      wait_cnt <= '0;
      trap_bus <= 1'b0;
      zext     <= 1'b0;
    end else begin
      wait_cnt <= '0;
      case (cur)
        S_IDLE: cur <= S_FETCH;
        S_FETCH, S_MEMRD, S_MEMWR: begin
          if (mem_ready) begin
            case (cur)
              S_FETCH: cur <= S_DECODE;
              S_MEMRD: cur <= S_MEMWB;
              default: cur <= S_FETCH;
            endcase
          end else if (at_limit) begin
            cur      <= S_TRAP;
            trap_bus <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + TIMEOUT_W'(1);
          end
        end
        S_DECODE: begin
          trap_bus <= 1'b0;
          zext     <= (op == 6'b001100) || (op == 6'b001101) || (op == 6'b001110);
          if (op == OP_LW || op == OP_SW)       cur <= S_MEMADR;
          else if (op == OP_RTYPE)              cur <= S_RTYPE;
          else if (op[5:3] == 3'b001)           cur <= S_IMMEX;
          else if (op == OP_BEQ)                cur <= S_BEQ;
          else if (HAS_BNE && op == OP_BNE)     cur <= S_BNE;
          else if (op == OP_J)                  cur <= S_JUMP;
          else                                  cur <= S_TRAP;
        end
        S_MEMADR: cur <= (op == OP_LW) ? S_MEMRD : S_MEMWR;
        S_RTYPE:  cur <= S_ALUWB;
        S_IMMEX:  cur <= S_IMMWB;
        S_BAD:    cur <= S_IDLE;
        default:  cur <= S_FETCH;
      endcase
    end
  end

  // Moore decode of the state register; only the FETCH-stage IR/PC loads
  // look at mem_ready so nothing is written until the fetch completes.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    iord      = 1'b0;
    irwrite   = 1'b0;
    pcwrite   = 1'b0;
    branch    = 1'b0;
    branch_ne = 1'b0;
    regdst    = 1'b0;
    memtoreg  = 1'b0;
    regwrite  = 1'b0;
    ext_zero  = 1'b0;
    alusrca   = 1'b0;
    alusrcb   = 2'b00;
    aluop     = 2'b00;
    pcsrc     = 2'b00;
    exc_ri    = 1'b0;
    exc_bus   = 1'b0;
    case (cur)
      S_FETCH: begin
        mem_req = 1'b1;
        alusrcb = 2'b01;
        irwrite = mem_ready;
        pcwrite = mem_ready;
      end
      S_DECODE: alusrcb = 2'b11;
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      S_MEMWR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
      end
      S_RTYPE: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      S_ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      S_IMMEX: begin
        alusrca  = 1'b1;
        alusrcb  = 2'b10;
        aluop    = 2'b11;
        ext_zero = zext;
      end
      S_IMMWB: begin
        regwrite = 1'b1;
        ext_zero = zext;
      end
      S_BEQ, S_BNE: begin
        alusrca   = 1'b1;
        aluop     = 2'b01;
        pcsrc     = 2'b01;
        branch    = (cur == S_BEQ);
        branch_ne = (cur == S_BNE);
      end
      S_JUMP: begin
        pcwrite = 1'b1;
        pcsrc   = 2'b10;
      end
      S_TRAP: begin
        exc_ri  = ~trap_bus;
        exc_bus = trap_bus;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: self-checking bench for mc_ctrl. Two instances share inputs:
// dut_a (TIMEOUT=4, HAS_BNE=1) and dut_b (timeout disabled, HAS_BNE=0).
// Each instruction is expanded into its expected per-cycle state trace
// (including wait states and traps) from the instruction-level rules, and
// every cycle's full output vector is compared against that trace.
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op;
  logic       mem_ready;

  always #5 clk = ~clk;

  logic       a_mem_req, a_mem_we, a_iord, a_irwrite, a_pcwrite, a_branch, a_branch_ne;
  logic       a_regdst, a_memtoreg, a_regwrite, a_ext_zero, a_alusrca, a_exc_ri, a_exc_bus;
  logic [1:0] a_alusrcb, a_aluop, a_pcsrc;
  logic [3:0] a_state;
  logic       b_mem_req, b_mem_we, b_iord, b_irwrite, b_pcwrite, b_branch, b_branch_ne;
  logic       b_regdst, b_memtoreg, b_regwrite, b_ext_zero, b_alusrca, b_exc_ri, b_exc_bus;
  logic [1:0] b_alusrcb, b_aluop, b_pcsrc;
  logic [3:0] b_state;

  mc_ctrl #(.TIMEOUT(4), .TIMEOUT_W(8), .HAS_BNE(1'b1)) dut_a (
    .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
    .mem_req(a_mem_req), .mem_we(a_mem_we), .iord(a_iord), .irwrite(a_irwrite),
    .pcwrite(a_pcwrite), .branch(a_branch), .branch_ne(a_branch_ne), .regdst(a_regdst),
    .memtoreg(a_memtoreg), .regwrite(a_regwrite), .ext_zero(a_ext_zero),
    .alusrca(a_alusrca), .alusrcb(a_alusrcb), .aluop(a_aluop), .pcsrc(a_pcsrc),
    .exc_ri(a_exc_ri), .exc_bus(a_exc_bus), .state(a_state)
  );

  mc_ctrl #(.TIMEOUT(0), .TIMEOUT_W(8), .HAS_BNE(1'b0)) dut_b (
    .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
    .mem_req(b_mem_req), .mem_we(b_mem_we), .iord(b_iord), .irwrite(b_irwrite),
    .pcwrite(b_pcwrite), .branch(b_branch), .branch_ne(b_branch_ne), .regdst(b_regdst),
    .memtoreg(b_memtoreg), .regwrite(b_regwrite), .ext_zero(b_ext_zero),
    .alusrca(b_alusrca), .alusrcb(b_alusrcb), .aluop(b_aluop), .pcsrc(b_pcsrc),
    .exc_ri(b_exc_ri), .exc_bus(b_exc_bus), .state(b_state)
  );

  // {mem_req,mem_we,iord,irwrite,pcwrite,branch,branch_ne,regdst,memtoreg,
  //  regwrite,ext_zero,alusrca,alusrcb,aluop,pcsrc,exc_ri,exc_bus,state}
  logic [23:0] vec_a, vec_b;
  assign vec_a = {a_mem_req, a_mem_we, a_iord, a_irwrite, a_pcwrite, a_branch, a_branch_ne,
                  a_regdst, a_memtoreg, a_regwrite, a_ext_zero, a_alusrca, a_alusrcb,
                  a_aluop, a_pcsrc, a_exc_ri, a_exc_bus, a_state};
  assign vec_b = {b_mem_req, b_mem_we, b_iord, b_irwrite, b_pcwrite, b_branch, b_branch_ne,
                  b_regdst, b_memtoreg, b_regwrite, b_ext_zero, b_alusrca, b_alusrcb,
                  b_aluop, b_pcsrc, b_exc_ri, b_exc_bus, b_state};

  typedef struct {
    int st;
    bit drv;
    bit bus;
  } cyc_t;

  cyc_t q[$];
  int   total = 0;
  int   bad   = 0;
  bit   sel;
  int   tmo;
  bit   hasbne;

  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] SW  = 6'b101011;
  localparam logic [5:0] RT  = 6'b000000;
  localparam logic [5:0] ORI = 6'b001101;
  localparam logic [5:0] BEQ = 6'b000100;
  localparam logic [5:0] BNE = 6'b000101;
  localparam logic [5:0] JMP = 6'b000010;
  localparam logic [5:0] RSV = 6'b111111;

  // Expected output vector for one cycle spent in state st.
  function automatic logic [23:0] expv(int st, logic rdy, logic bus, logic [5:0] o);
    logic mreq, mwe, io, irw, pcw, br, brne, rd, m2r, rw, ez, asa, eri, ebus;
    logic [1:0] asb, aop, psrc;
    {mreq, mwe, io, irw, pcw, br, brne, rd, m2r, rw, ez, asa, eri, ebus} = '0;
    asb = 2'b00; aop = 2'b00; psrc = 2'b00;
    case (st)
      1:  begin mreq = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
      2:  asb = 2'b11;
      3:  begin asa = 1; asb = 2'b10; end
      4:  begin mreq = 1; io = 1; end
      5:  begin m2r = 1; rw = 1; end
      6:  begin mreq = 1; mwe = 1; io = 1; end
      7:  begin asa = 1; aop = 2'b10; end
      8:  begin rd = 1; rw = 1; end
      9:  begin asa = 1; asb = 2'b10; aop = 2'b11; ez = (o == 6'd12 || o == 6'd13 || o == 6'd14); end
      10: begin rw = 1; ez = (o == 6'd12 || o == 6'd13 || o == 6'd14); end
      11: begin asa = 1; aop = 2'b01; br = 1; psrc = 2'b01; end
      12: begin asa = 1; aop = 2'b01; brne = 1; psrc = 2'b01; end
      13: begin pcw = 1; psrc = 2'b10; end
      14: begin eri = ~bus; ebus = bus; end
      default: ;
    endcase
    return {mreq, mwe, io, irw, pcw, br, brne, rd, m2r, rw, ez, asa, asb, aop, psrc,
            eri, ebus, 4'(st)};
  endfunction

  task automatic checkOutput(input string tag, input logic [23:0] want);
    logic [23:0] obs;
    obs = sel ? vec_b : vec_a;
    total++;
    assert (obs === want) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  task automatic applyStimulus(input cyc_t c, input logic [5:0] o);
    @(negedge clk);
    mem_ready = c.drv;
    #1;
    checkOutput($sformatf("dut%s op=%b st=%0d", sel ? "b" : "a", o, c.st),
                expv(c.st, c.drv, c.bus, o));
  endtask

  task automatic push(input int st, input bit drv, input bit bus);
    cyc_t c;
    c.st = st; c.drv = drv; c.bus = bus;
    q.push_back(c);
  endtask

  // A memory access of w wait states, or a bus trap if w reaches the limit.
  task automatic addWait(input int st, input int w, output bit aborted);
    int n;
    aborted = (tmo != 0) && (w >= tmo);
    n = aborted ? tmo : w;
    for (int i = 0; i < n; i++) push(st, 1'b0, 1'b0);
    if (aborted) push(14, 1'($urandom_range(0, 1)), 1'b1);
    else         push(st, 1'b1, 1'b0);
  endtask

  task automatic runInstr(input logic [5:0] o, input int wf, input int wm, input int ncyc);
    bit ab;
    int done;
    q.delete();
    op = o;
    addWait(1, wf, ab);
    if (!ab) begin
      push(2, 1'($urandom_range(0, 1)), 1'b0);
      if (o == LW || o == SW) begin
        push(3, 1'($urandom_range(0, 1)), 1'b0);
        if (o == LW) begin
          addWait(4, wm, ab);
          if (!ab) push(5, 1'($urandom_range(0, 1)), 1'b0);
        end else begin
          addWait(6, wm, ab);
        end
      end else if (o == RT) begin
        push(7, 1'($urandom_range(0, 1)), 1'b0);
        push(8, 1'($urandom_range(0, 1)), 1'b0);
      end else if (o[5:3] == 3'b001) begin
        push(9, 1'($urandom_range(0, 1)), 1'b0);
        push(10, 1'($urandom_range(0, 1)), 1'b0);
      end else if (o == BEQ) begin
        push(11, 1'($urandom_range(0, 1)), 1'b0);
      end else if (o == BNE && hasbne) begin
        push(12, 1'($urandom_range(0, 1)), 1'b0);
      end else if (o == JMP) begin
        push(13, 1'($urandom_range(0, 1)), 1'b0);
      end else begin
        push(14, 1'($urandom_range(0, 1)), 1'b0);
      end
    end
    done = 0;
    while (q.size() > 0 && (ncyc < 0 || done < ncyc)) begin
      applyStimulus(q.pop_front(), o);
      done++;
    end
  endtask

  // Asynchronous reset; release just after an edge so IDLE is seen one cycle.
  task automatic applyReset();
    cyc_t c;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("reset_async", expv(0, 1'b0, 1'b0, op));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    c.st = 0; c.drv = 1'($urandom_range(0, 1)); c.bus = 1'b0;
    applyStimulus(c, op);
  endtask

  function automatic logic [5:0] pickOp();
    logic [5:0] tbl [8];
    int r;
    tbl = '{LW, SW, RT, ORI, BEQ, BNE, JMP, RSV};
    r = $urandom_range(0, 9);
    if (r < 8)  return tbl[r];
    if (r == 8) return {3'b001, 3'($urandom_range(0, 7))};
    return 6'($urandom_range(0, 63));
  endfunction

  initial begin
    sel = 1'b0; tmo = 4; hasbne = 1'b1;
    rst = 1'b1; op = RT; mem_ready = 1'b0;
    applyReset();
    runInstr(LW, 0, 6, 5);
    applyReset();
    runInstr(LW, 0, 0, -1);
    runInstr(ORI, 2, 0, -1);
    runInstr(BNE, 0, 0, -1);
    runInstr(BEQ, 1, 0, -1);
    runInstr(JMP, 0, 0, -1);
    runInstr(RSV, 0, 0, -1);
    runInstr(SW, 0, 4, -1);
    runInstr(SW, 0, 3, -1);
    runInstr(LW, 0, 5, -1);
    runInstr(RT, 6, 0, -1);
    runInstr(6'b001100, 0, 0, -1);
    for (int i = 0; i < 60; i++)
      runInstr(pickOp(), $urandom_range(0, 5), $urandom_range(0, 5), -1);

    sel = 1'b1; tmo = 0; hasbne = 1'b0;
    applyReset();
    runInstr(BNE, 0, 0, -1);
    runInstr(SW, 0, 9, -1);
    runInstr(LW, 7, 2, -1);
    for (int i = 0; i < 30; i++)
      runInstr(pickOp(), $urandom_range(0, 7), $urandom_range(0, 7), -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
